// File: rtl/traffic_pkg.sv
// Shared traffic-lane definitions: scheduler state encoding, stage speed
// multipliers and the playfield geometry shared with renderer and collision.
package traffic_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_PAUSED,
      S_HALT
   } sched_state_t;

   // Base-tick stretch factor per stage (slowest at stage 0)
   localparam logic [1:0] MULT_STAGE0 = 2'd3;
   localparam logic [1:0] MULT_STAGE1 = 2'd2;
   localparam logic [1:0] MULT_STAGE2 = 2'd1;
   localparam logic [1:0] MULT_STAGE3 = 2'd1;

   localparam int DEF_X_MIN = 207;
   localparam int DEF_X_MAX = 431;
   localparam int DEF_OBJ_W = 32;

   function automatic logic [1:0] stage_mult(input logic [1:0] s);
      logic [1:0] m;
      case (s)
         2'd0:    m = MULT_STAGE0;
         2'd1:    m = MULT_STAGE1;
         2'd2:    m = MULT_STAGE2;
         default: m = MULT_STAGE3;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Base-tick prescaler: counts 0..TICK_DIV*M-1 then pulses o_tick for one
// cycle. M is latched on clear and at every wrap.
// Ports: i_clk, i_rst (async, active-high), i_mult (M, 1..3),
//        i_en (count enable), i_clr (sync clear), o_tick (1-cycle pulse).
module tick_prescaler
   import traffic_pkg::*;
#(
   parameter int TICK_DIV = 500000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [1:0] i_mult,
   input  logic       i_en,
   input  logic       i_clr,
   output logic       o_tick
);

   localparam int CW = $clog2(3 * TICK_DIV);

   logic [CW-1:0] r_cnt;
   logic [CW-1:0] r_lim;
   logic [CW-1:0] w_lim;
   logic          r_tick;

   assign w_lim  = CW'(int'(i_mult) * TICK_DIV - 1);
   assign o_tick = r_tick;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt  <= '0;
         r_lim  <= CW'(TICK_DIV - 1);
         r_tick <= 1'b0;
      end else if (i_clr) begin
         r_cnt  <= '0;
         r_lim  <= w_lim;
         r_tick <= 1'b0;
      end else begin
         r_tick <= 1'b0;
         if (i_en) begin
            if (r_cnt == r_lim) begin
               r_cnt  <= '0;
               r_lim  <= w_lim;
               r_tick <= 1'b1;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/traffic_scheduler.sv
// Central lane motion controller: one shared prescaler and one shared
// step/wrap datapath swept round-robin across all lanes after each base tick.
// Ports: Reset (async, active-high), frame_clk, start, game_over, stage,
//        pause, lane_init_x, lane_dir, lane_period -> laneX, step_strobe,
//        running. Optional macro SCHED_PAUSE_EN enables the PAUSED state.
module traffic_scheduler
   import traffic_pkg::*;
#(
   parameter int NUM_LANES = 4,
   parameter int TICK_DIV  = 500000,
   parameter int X_MIN     = DEF_X_MIN,
   parameter int X_MAX     = DEF_X_MAX,
   parameter int OBJ_W     = DEF_OBJ_W
) (
   input  logic                      Reset,
   input  logic                      frame_clk,
   input  logic                      start,
   input  logic                      game_over,
   input  logic [1:0]                stage,
   input  logic                      pause,
   input  logic [NUM_LANES*10-1:0]   lane_init_x,
   input  logic [NUM_LANES-1:0]      lane_dir,
   input  logic [NUM_LANES*4-1:0]    lane_period,
   output logic [NUM_LANES*10-1:0]   laneX,
   output logic [NUM_LANES-1:0]      step_strobe,
   output logic                      running
);

   localparam int IW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

   sched_state_t r_state;
   sched_state_t w_next;

   logic [9:0]           r_x   [NUM_LANES];
   logic [3:0]           r_cnt [NUM_LANES];
   logic [NUM_LANES-1:0] r_strobe;
   logic                 r_busy;
   logic [IW-1:0]        r_idx;

   logic [9:0] w_init [NUM_LANES];
   logic [3:0] w_per  [NUM_LANES];

   logic       w_tick;
   logic       w_pause;
   logic [9:0] w_x;
   logic [10:0] w_x11;
   logic [9:0] w_x_step;
   logic       w_dir;
   logic [3:0] w_per_s;
   logic [3:0] w_cnt_s;
   logic [4:0] w_cnt_inc;
   logic       w_hit;
   logic       w_over;

`ifdef SCHED_PAUSE_EN
   assign w_pause = pause;
`else
   logic w_unused_pause;
   assign w_unused_pause = pause;
   assign w_pause = 1'b0;
`endif

   genvar g;
   generate
      for (g = 0; g < NUM_LANES; g++) begin : g_lane
         assign w_init[g]          = lane_init_x[10*g +: 10];
         assign w_per[g]           = lane_period[4*g +: 4];
         assign laneX[10*g +: 10]  = r_x[g];
      end
   endgenerate

   assign step_strobe = r_strobe;
   assign running     = (r_state == S_RUN) || (r_state == S_PAUSED);

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_presc (
      .i_clk  (frame_clk),
      .i_rst  (Reset),
      .i_mult (stage_mult(stage)),
      .i_en   (r_state == S_RUN),
      .i_clr  (r_state == S_LOAD),
      .o_tick (w_tick)
   );

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (start) w_next = S_LOAD;
         S_LOAD:   w_next = S_RUN;
         S_RUN: begin
            if (game_over)    w_next = S_HALT;
            else if (w_pause) w_next = S_PAUSED;
         end
         S_PAUSED: begin
            if (game_over)     w_next = S_HALT;
            else if (!w_pause) w_next = S_RUN;
         end
         S_HALT:   if (start) w_next = S_LOAD;
         default:  w_next = S_IDLE;
      endcase
   end

   // Shared datapath: selected lane's counter update and step/wrap result
   always_comb begin
      w_x       = r_x[r_idx];
      w_dir     = lane_dir[r_idx];
      w_per_s   = w_per[r_idx];
      w_cnt_s   = r_cnt[r_idx];
      w_x11     = {1'b0, w_x};
      w_cnt_inc = {1'b0, w_cnt_s} + 5'd1;
      w_hit     = (w_per_s != 4'd0) && (w_cnt_inc == {1'b0, w_per_s});
      // A period lowered below the running count clears it without a step
      w_over    = (w_per_s != 4'd0) && (w_cnt_s >= w_per_s);
      if (!w_dir) begin
         if (w_x11 + 11'(OBJ_W) < 11'(X_MIN)) w_x_step = 10'(X_MAX);
         else                                w_x_step = w_x - 10'd1;
      end else begin
         if (w_x11 > 11'(X_MAX)) w_x_step = 10'(X_MIN - OBJ_W);
         else                    w_x_step = w_x + 10'd1;
      end
   end

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            r_x[i]   <= '0;
            r_cnt[i] <= '0;
         end
         r_strobe <= '0;
         r_busy   <= 1'b0;
         r_idx    <= '0;
      end else begin
         r_strobe <= '0;
         case (r_state)
            S_IDLE: begin
               for (int i = 0; i < NUM_LANES; i++) r_x[i] <= w_init[i];
               r_busy <= 1'b0;
            end
            S_LOAD: begin
               for (int i = 0; i < NUM_LANES; i++) begin
                  r_x[i]   <= w_init[i];
                  r_cnt[i] <= '0;
               end
               r_busy <= 1'b0;
               r_idx  <= '0;
            end
            S_RUN: begin
               if (r_busy) begin
                  if (w_hit) begin
                     r_cnt[r_idx]    <= '0;
                     r_x[r_idx]      <= w_x_step;
                     r_strobe[r_idx] <= 1'b1;
                  end else if (w_over) begin
                     r_cnt[r_idx] <= '0;
                  end else begin
                     r_cnt[r_idx] <= w_cnt_inc[3:0];
                  end
                  if (r_idx == IW'(NUM_LANES - 1)) r_busy <= 1'b0;
                  else                             r_idx  <= r_idx + 1'b1;
               end else if (w_tick) begin
                  r_busy <= 1'b1;
                  r_idx  <= '0;
               end
            end
            S_PAUSED: begin
               // A tick raised by the last RUN cycle is still honoured
               if (w_tick && !r_busy) begin
                  r_busy <= 1'b1;
                  r_idx  <= '0;
               end
            end
            default: r_busy <= 1'b0;
         endcase
      end
   end

endmodule

// File: doc/traffic_scheduler.md
# traffic_scheduler

Central motion controller for all traffic lanes of the playfield. It replaces per-lane free-running movers with one shared tick prescaler and one shared step/wrap datapath. The datapath is time-multiplexed round-robin across lanes. It sits between the game-state logic (start, stage, game-over) and the sprite renderer/collision logic, which consume the per-lane X positions.

## Interface
Parameters:
- NUM_LANES, 4: number of independently moving lanes.
- TICK_DIV, 500000: frame_clk cycles per base tick. Must satisfy TICK_DIV > NUM_LANES + 1.
- X_MIN, 207: left playfield edge.
- X_MAX, 431: right re-entry / far edge.
- OBJ_W, 32: object width in pixels.

Ports:
- Reset  in  1  asynchronous, active-high reset.
- frame_clk  in  1  clock.
- start  in  1  level; sampled in IDLE/HALT to begin a round.
- game_over  in  1  level; stops motion.
- stage  in  2  speed level, sampled at each base tick.
- pause  in  1  freeze request. Effective only with SCHED_PAUSE_EN.
- lane_init_x  in  NUM_LANES*10  per-lane spawn X; lane i occupies bits [10i+9:10i].
- lane_dir  in  NUM_LANES  per-lane direction; 0 = left, 1 = right.
- lane_period  in  NUM_LANES*4  base ticks per 1-pixel step; 0 = lane frozen.
- laneX  out  NUM_LANES*10  registered lane X positions.
- step_strobe  out  NUM_LANES  one-cycle pulse, coincident with the lane's laneX update.
- running  out  1  high in RUN (and PAUSED).

## Operation
- FSM states: IDLE, LOAD, RUN, PAUSED, HALT. Reset enters IDLE.
  - IDLE: laneX <= lane_init_x every cycle. start=1 -> LOAD.
  - LOAD: one cycle. Copies lane_init_x, clears the prescaler and all lane counters, then -> RUN.
  - RUN: prescaler counts.
    - game_over=1 -> HALT; has priority over pause.
    - pause=1 -> PAUSED (macro only).
  - PAUSED: prescaler, lane counters and positions hold. pause=0 -> RUN. game_over=1 -> HALT.
  - HALT: positions hold. start=1 -> LOAD.
- Prescaler: counts 0..TICK_DIV*M-1, then emits a base tick. M by stage: 0->3, 1->2, 2->1, 3->1. M is latched at each tick.
- On base tick, start a sweep: lane index 0..NUM_LANES-1, one lane per cycle through the shared datapath.
  - Lane counter increments.
  - If lane_period != 0 and counter+1 == lane_period: counter clears and the lane steps.
- Step, left (dir=0):
  - if x + OBJ_W < X_MIN then x = X_MAX
  - else x = x - 1
- Step, right (dir=1):
  - if x > X_MAX then x = X_MIN - OBJ_W
  - else x = x + 1
- Arithmetic and compares are 11-bit zero-extended. Results are truncated to 10 bits.
- lane_period changed mid-round: counter >= new period clears without stepping on its next slot.
- game_over during a sweep: the remaining lanes are not processed; positions freeze at their current values.

## Timing
- Reset values: laneX = 0, step_strobe = 0, running = 0, state IDLE, counters 0.
- IDLE tracking latency: 1 cycle from lane_init_x to laneX.
- First base tick: TICK_DIV*M cycles after entering RUN.
- Lane i is processed in cycle tick+1+i.
- laneX[i] and step_strobe[i] update at the end of that cycle.
- Only one lane changes per cycle.
- Reset mid-sweep aborts immediately, with no partial update.
- start held high continuously re-enters LOAD only from IDLE/HALT, never from RUN.

## Configuration
- SCHED_PAUSE_EN defined: PAUSED state and the pause input are active.
- SCHED_PAUSE_EN undefined: the pause port exists but is ignored. The FSM never enters PAUSED, and RUN exits only via game_over.

## Structure
- Package traffic_pkg holds:
  - the sched_state_t enum;
  - the stage-to-multiplier constants;
  - default X_MIN/X_MAX/OBJ_W constants, shared with the renderer and collision logic.
- Sub-module tick_prescaler: parameter TICK_DIV; inputs multiplier, enable, clear; output tick pulse.

## Test plan
All scenarios use TICK_DIV=8.
- Reset, then start, stage=2, lane0 init 300, dir 0, period 1 -> laneX0 = 299 at cycle 1+8+1 after RUN entry, then 298 eight cycles later.
- Left wrap: lane0 at 174, dir 0 -> next step 431 (174+32=206 < 207). At 175, the next step gives 174.
- Right wrap: lane1 at 432, dir 1 -> next step 175. At 431, the next step gives 432.
- stage=0 with period 2 -> one step per 48 cycles. stage=1 -> one step per 32 cycles. Strobes of lanes 0..3 occur in consecutive cycles.
- game_over asserted one cycle after a tick -> lane0 updated, lanes 1..3 unchanged, running=0. Then start -> laneX reloaded from lane_init_x and the counters restart.
- With SCHED_PAUSE_EN, pause for 100 cycles -> laneX frozen and the next step is delayed by exactly 100 cycles. Without the macro, pause has no effect.
